feed_msg_assembler: RTL and testbench

- Sits directly downstream of feed_decoder, on its per-message Avalon-ST output.
- Collects the 1-4 beats of each message into one flat, MSB-aligned record, up to 32 bytes.
- Presents the record with its byte length and an error flag on a single-register valid/ready output.
- The downstream field parser sees one parallel word per message.

---
 rtl/feed_msg_assembler.sv | 173 +++++++++++++++++
 tb/tb_feed_msg_assembler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feed_msg_assembler.sv
// rtl/feed_msg_assembler.sv - collects the 1-4 beats of a feed message into one MSB-aligned record
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   in_*               Avalon-ST beat input from the feed decoder (ready/valid/sop/eop/data/empty/error)
//   out_valid/ready    one record per message, held stable until taken
//   out_data           message bytes, byte 0 in the top byte lane, unused bytes zero
//   out_len            message length in bytes (1..32)
//   out_error          runt message or upstream error on any beat
//   drop_cnt           saturating count of discarded messages/beats

module feed_msg_assembler #(
  parameter int C_PKT_BEAT_BYTES  = 8,
  parameter int C_MSG_MIN_BYTES   = 8,
  parameter int C_MSG_MAX_BYTES   = 32,
  parameter int C_PKT_DATA_WIDTH  = C_PKT_BEAT_BYTES * 8,
  parameter int C_PKT_EMPTY_WIDTH = $clog2(C_PKT_BEAT_BYTES),
  parameter int C_MSG_DATA_WIDTH  = C_MSG_MAX_BYTES * 8,
  parameter int C_MSG_LEN_WIDTH   = $clog2(C_MSG_MAX_BYTES) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         in_ready,
  input  logic                         in_valid,
  input  logic                         in_startofpacket,
  input  logic                         in_endofpacket,
  input  logic [C_PKT_DATA_WIDTH-1:0]  in_data,
  input  logic [C_PKT_EMPTY_WIDTH-1:0] in_empty,
  input  logic                         in_error,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [C_MSG_DATA_WIDTH-1:0]  out_data,
  output logic [C_MSG_LEN_WIDTH-1:0]   out_len,
  output logic                         out_error,
  output logic [15:0]                  drop_cnt
);

  localparam int C_MAX_BEATS = C_MSG_MAX_BYTES / C_PKT_BEAT_BYTES;
  localparam int C_IDX_WIDTH = $clog2(C_MAX_BEATS);
  localparam logic [C_IDX_WIDTH-1:0] LAST_IDX = C_IDX_WIDTH'(C_MAX_BEATS - 1);
  localparam logic [C_IDX_WIDTH-1:0] IDX_ONE  = C_IDX_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DROP, S_HOLD} state_t;

  state_t                      state, state_n;
  logic [C_IDX_WIDTH-1:0]      beat_idx, idx_n, lane;
  logic [C_MSG_DATA_WIDTH-1:0] rec, rec_n;
  logic [C_MSG_LEN_WIDTH-1:0]  len_q, len_n;
  logic                        err_q, oerr_n;
  logic                        err_acc, eacc_n;
  logic [15:0]                 drop_q;
  logic                        accept, drop_inc, start, append;
  logic [C_PKT_DATA_WIDTH-1:0] beat_masked;

  // Ready is forced low while reset is asserted, not just after the first reset edge.
  assign in_ready  = !reset && (state != S_HOLD);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_HOLD);
  assign out_data  = rec;
  assign out_len   = len_q;
  assign out_error = err_q;
  assign drop_cnt  = drop_q;

  // Zero the unused trailing bytes of the eop beat so the record tail reads as zero.
  always_comb begin
    beat_masked = in_data;
    if (in_endofpacket) begin
      for (int b = 0; b < C_PKT_BEAT_BYTES; b++) begin
        if (b >= C_PKT_BEAT_BYTES - int'(in_empty)) begin
          beat_masked[8*(C_PKT_BEAT_BYTES-1-b) +: 8] = '0;
        end
      end
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = beat_idx;
    rec_n    = rec;
    len_n    = len_q;
    oerr_n   = err_q;
    eacc_n   = err_acc;
    drop_inc = 1'b0;
    start    = 1'b0;
    append   = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_startofpacket) begin
            start = 1'b1;
          end else begin
            drop_inc = 1'b1;
            if (!in_endofpacket) state_n = S_DROP;
          end
        end
      end
      S_ACCUM: begin
        if (accept) begin
          if (in_startofpacket) begin
            // restart: the partial record counts as one drop
            drop_inc = 1'b1;
            start    = 1'b1;
          end else if (in_endofpacket) begin
            append  = 1'b1;
            state_n = S_HOLD;
          end else if (beat_idx == LAST_IDX) begin
            // a further beat without eop cannot fit the record
            drop_inc = 1'b1;
            state_n  = S_DROP;
          end else begin
            append = 1'b1;
            idx_n  = beat_idx + IDX_ONE;
          end
        end
      end
      S_DROP: begin
        if (accept) begin
          if (in_startofpacket)    start   = 1'b1;
          else if (in_endofpacket) state_n = S_IDLE;
        end
      end
      S_HOLD: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    lane = start ? '0 : beat_idx;

    if (start) begin
      rec_n   = '0;
      idx_n   = IDX_ONE;
      eacc_n  = in_error;
      state_n = in_endofpacket ? S_HOLD : S_ACCUM;
    end else if (append) begin
      eacc_n = err_acc | in_error;
    end

    if (start || append) begin
      for (int l = 0; l < C_MAX_BEATS; l++) begin
        if (C_IDX_WIDTH'(l) == lane) begin
          rec_n[C_MSG_DATA_WIDTH-1-C_PKT_DATA_WIDTH*l -: C_PKT_DATA_WIDTH] = beat_masked;
        end
      end
      if (in_endofpacket) begin
        len_n  = C_MSG_LEN_WIDTH'(C_PKT_BEAT_BYTES * (int'(lane) + 1) - int'(in_empty));
        oerr_n = eacc_n | (len_n < C_MSG_LEN_WIDTH'(C_MSG_MIN_BYTES));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      beat_idx <= '0;
      rec      <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      err_acc  <= 1'b0;
      drop_q   <= '0;
    end else begin
      state    <= state_n;
      beat_idx <= idx_n;
      rec      <= rec_n;
      len_q    <= len_n;
      err_q    <= oerr_n;
      err_acc  <= eacc_n;
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_feed_msg_assembler.sv
// tb/tb_feed_msg_assembler.sv - self-checking bench for feed_msg_assembler with a message-level model

module tb_feed_msg_assembler;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_ready;
  logic         in_valid;
  logic         in_startofpacket;
  logic         in_endofpacket;
  logic [63:0]  in_data;
  logic [2:0]   in_empty;
  logic         in_error;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic [5:0]   out_len;
  logic         out_error;
  logic [15:0]  drop_cnt;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  feed_msg_assembler dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_data(in_data), .in_empty(in_empty), .in_error(in_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_len(out_len), .out_error(out_error), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Message-level reference: mode 0 = between messages, 1 = collecting, 2 = discarding.
  bit           m_hold  = 0;
  logic [255:0] m_data  = '0;
  int           m_len   = 0;
  bit           m_err   = 0;
  int           m_drops = 0;
  int           m_mode  = 0;
  int           m_nb    = 0;
  bit           m_eacc  = 0;
  logic [7:0]   m_bytes [32];

  task automatic m_drop();
    if (m_drops < 65535) m_drops++;
  endtask

  task automatic m_take();
    for (int j = 0; j < 8; j++) m_bytes[8*m_nb+j] = in_data[63-8*j -: 8];
    m_nb++;
    m_eacc = m_eacc | in_error;
    if (in_endofpacket) begin
      m_len  = 8*m_nb - int'(in_empty);
      m_data = '0;
      for (int i = 0; i < m_len; i++) m_data[255-8*i -: 8] = m_bytes[i];
      m_err  = m_eacc || (m_len < 8);
      m_hold = 1;
      m_mode = 0;
    end
  endtask

  task automatic m_beat();
    if (in_startofpacket) begin
      if (m_mode == 1) m_drop();
      m_mode = 1; m_nb = 0; m_eacc = 0;
      m_take();
    end else if (m_mode == 0) begin
      m_drop();
      if (!in_endofpacket) m_mode = 2;
    end else if (m_mode == 2) begin
      if (in_endofpacket) m_mode = 0;
    end else if (!in_endofpacket && m_nb == 3) begin
      m_drop();
      m_mode = 2;
    end else begin
      m_take();
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_hold = 0; m_mode = 0; m_drops = 0; m_nb = 0;
    end else begin
      bit acc;
      acc = in_valid && !m_hold;
      if (m_hold && out_ready) m_hold = 0;
      if (acc) m_beat();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", in_ready, !reset && !m_hold);
      chk("out_valid", out_valid, m_hold);
      chk("drop_cnt", drop_cnt, m_drops);
      if (m_hold) begin
        chk("out_data", out_data, m_data);
        chk("out_len", out_len, m_len);
        chk("out_error", out_error, m_err);
      end
    end
  end

  function automatic logic [63:0] seq_beat(input logic [7:0] first);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[63-8*j -: 8] = first + 8'(j);
    return d;
  endfunction

  // Holds the beat until it is accepted; returns #1 after the accepting edge.
  task automatic send(input bit sop, input bit eop, input logic [63:0] d,
                      input logic [2:0] emp, input bit err);
    bit done;
    int t;
    done = 0; t = 0;
    in_valid = 1; in_startofpacket = sop; in_endofpacket = eop;
    in_data = d; in_empty = emp; in_error = err;
    while (!done) begin
      done = in_ready;
      @(posedge clk); #1;
      t++;
      if (!done && t > 50) begin
        n_total++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
        done = 1;
      end
    end
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int cnt;
    reset = 1; in_valid = 0; in_startofpacket = 0; in_endofpacket = 0;
    in_data = '0; in_empty = '0; in_error = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_out_error", out_error, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    reset = 0;
    cmp_en = 1;
    #1 chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // 4-beat full-size message
    out_ready = 1;
    for (int k = 0; k < 4; k++) send(k == 0, k == 3, seq_beat(8'(8*k)), 3'd0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    chk("t1_len", out_len, 32);
    chk("t1_err", out_error, 0);
    idle(2);

    // 2-beat, empty=3, stalled output
    out_ready = 0;
    send(1, 0, seq_beat(8'hA0), 3'd0, 0);
    send(0, 1, seq_beat(8'hA8), 3'd3, 0);
    chk("t2_len", out_len, 13);
    chk("t2_err", out_error, 0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1; in_startofpacket = 1; in_endofpacket = 1;
      in_data = {$urandom, $urandom}; in_empty = 3'd0;
      chk("t2_hold_ready", in_ready, 0);
      chk("t2_hold_data", out_data, {104'hA0A1A2A3A4A5A6A7A8A9AAABAC, 152'h0});
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("t2_taken", out_valid, 0);
    idle(1);

    // runt
    send(1, 1, seq_beat(8'h11), 3'd4, 0);
    chk("t3_len", out_len, 4);
    chk("t3_err", out_error, 1);
    chk("t3_data", out_data, {32'h11121314, 224'h0});
    idle(2);

    // back-to-back single-beat messages
    cnt = 0;
    in_valid = 1; in_startofpacket = 1; in_endofpacket = 1; in_empty = 3'd0; in_error = 0;
    for (int k = 0; k < 10; k++) begin
      in_data = {$urandom, $urandom};
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("b2b_records", cnt, 5);
    idle(2);

    // restart, then stray beats in IDLE
    send(1, 0, seq_beat(8'h40), 3'd0, 0);
    send(1, 1, seq_beat(8'h50), 3'd0, 0);
    chk("t4_drop1", drop_cnt, 1);
    chk("t4_data", out_data, {64'h5051525354555657, 192'h0});
    idle(2);
    send(0, 0, seq_beat(8'h60), 3'd0, 0);
    send(0, 1, seq_beat(8'h68), 3'd0, 0);
    idle(1);
    chk("t4_drop2", drop_cnt, 2);
    chk("t4_nothing", out_valid, 0);

    // oversize, then legal, then error on beat 2
    for (int k = 0; k < 5; k++) send(k == 0, k == 4, seq_beat(8'(8*k)), 3'd0, 0);
    idle(1);
    chk("t5_drop", drop_cnt, 3);
    chk("t5_nothing", out_valid, 0);
    send(1, 0, seq_beat(8'h70), 3'd0, 0);
    send(0, 1, seq_beat(8'h78), 3'd0, 0);
    chk("t5_len", out_len, 16);
    idle(2);
    send(1, 0, seq_beat(8'h80), 3'd0, 0);
    send(0, 0, seq_beat(8'h88), 3'd0, 1);
    send(0, 1, seq_beat(8'h90), 3'd0, 0);
    chk("t5_err", out_error, 1);
    chk("t5_len3", out_len, 24);
    idle(2);

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      in_valid         = ($urandom_range(0, 9) < 7);
      in_startofpacket = ($urandom_range(0, 9) < 3);
      in_endofpacket   = ($urandom_range(0, 9) < 4);
      in_data          = {$urandom, $urandom};
      in_empty         = 3'($urandom_range(0, 7));
      in_error         = ($urandom_range(0, 9) == 0);
      out_ready        = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    in_valid = 0; in_error = 0; out_ready = 1;
    idle(3);

    // reset while holding
    out_ready = 0;
    send(1, 1, {$urandom, $urandom}, 3'd0, 0);
    chk("t6_holding", out_valid, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("t6_valid", out_valid, 0);
    chk("t6_drop", drop_cnt, 0);
    idle(1);

    // saturation
    cmp_en = 0;
    in_valid = 1; in_startofpacket = 0; in_endofpacket = 1;
    repeat (65535) @(posedge clk);
    #1 chk("sat_reach", drop_cnt, 16'hFFFF);
    @(posedge clk); #1;
    chk("sat_hold", drop_cnt, 16'hFFFF);
    in_valid = 0;
    cmp_en = 1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
